imem_backing_ctrl: RTL and testbench

//  Main-memory model and controller directly downstream of the I-cache controller.

---
 rtl/imem_backing_ctrl.sv | 168 ++++++++++++++++
 tb/tb_imem_backing_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_backing_ctrl.sv
// rtl/imem_backing_ctrl.sv - instruction main-memory model serving one fixed-latency request at a time
//
// Purpose:
//   Backing store for the I-cache controller. It accepts one request at a time
//   from the cache, latches it, waits LATENCY cycles, and then completes it
//   against an internal array of 2**ADDR_W 32-bit words. Completion is signalled
//   by a one-cycle mem_data_ready pulse.
//
// Configuration:
//   IMEM_WRITE_EN  When defined, write requests update the array.
//                  When undefined, the array is read-only. Write requests are
//                  still accepted and acknowledged with the normal latency.
//
// Parameters:
//   ADDR_W   word-address bits (array depth is 2**ADDR_W words)
//   LATENCY  cycles from acceptance to the ready pulse, 1..15
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-low reset
//   mem_req_addr    byte address; word index = addr[ADDR_W+1:2], upper bits alias
//   mem_req_data    write data
//   mem_req_rw      0 = read, 1 = write
//   mem_req_valid   request valid, held by the cache until ready is seen
//   mem_data_data   registered read data, holds the last read value
//   mem_data_ready  one-cycle completion pulse
//   mem_busy        high while a request is waiting or responding
module imem_backing_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_req_addr,
  input  logic [31:0] mem_req_data,
  input  logic        mem_req_rw,
  input  logic        mem_req_valid,
  output logic [31:0] mem_data_data,
  output logic        mem_data_ready,
  output logic        mem_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  // The WAIT state counts down to zero, so it is loaded with LATENCY-2.
  // Entering RESP costs one more edge.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

`ifdef IMEM_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  // A constant-false write enable: the write port is pruned away, but the
  // array still has a single, well-defined driver.
  localparam bit WRITE_EN = 1'b0;
`endif

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "imem_backing_ctrl: LATENCY must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 14) begin : g_bad_addr_w
      $fatal(1, "imem_backing_ctrl: ADDR_W must be in 1..14");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_word;
  logic [31:0]       lat_data;
  logic              lat_rw;

  logic [31:0]       mem [0:DEPTH-1];

  logic [ADDR_W-1:0] req_word;
  logic              enter_resp;
  logic [ADDR_W-1:0] acc_word;
  logic [31:0]       acc_data;
  logic              acc_rw;
  logic              unused_addr_bits;

  // Byte-offset bits and bits above the array depth are dropped, so high
  // addresses alias onto the array.
  assign req_word         = mem_req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^mem_req_addr;

  // The array access happens on the edge that enters RESP. With LATENCY=1
  // that is the accepting edge itself, so the live request is used instead
  // of the latched copy.
  assign enter_resp = ((state == S_IDLE) && mem_req_valid && (LATENCY == 1)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  always_comb begin
    acc_word = lat_word;
    acc_data = lat_data;
    acc_rw   = lat_rw;
    if (state == S_IDLE) begin
      acc_word = req_word;
      acc_data = mem_req_data;
      acc_rw   = mem_req_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      mem_data_ready <= 1'b0;
      mem_data_data  <= 32'd0;
      mem_busy       <= 1'b0;
    end else begin
      mem_data_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (mem_req_valid) begin
            lat_word <= req_word;
            lat_data <= mem_req_data;
            lat_rw   <= mem_req_rw;
            mem_busy <= 1'b1;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // valid is deliberately not sampled here. The cache still holds it
          // high during the ready cycle, and sampling it would accept the
          // same request twice.
          state    <= S_IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          mem_busy <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        mem_data_ready <= 1'b1;
        if (!acc_rw) begin
          mem_data_data <= mem[acc_word];
        end
      end
    end
  end

  // Gated by rst so that a request aborted by reset never commits its write.
  always_ff @(posedge clk) begin
    if (WRITE_EN && rst && enter_resp && acc_rw) begin
      mem[acc_word] <= acc_data;
    end
  end

endmodule

// File: tb/tb_imem_backing_ctrl.sv
// tb/tb_imem_backing_ctrl.sv - scoreboard bench for imem_backing_ctrl (LATENCY 4 and LATENCY 1 instances)
module tb_imem_backing_ctrl;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT    = 4;
  localparam int LAT1   = 1;
`ifdef IMEM_WRITE_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        req_rw;
  logic        req_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        busy;

  logic [15:0] req1_addr;
  logic [31:0] req1_data;
  logic        req1_rw;
  logic        req1_valid;
  logic [31:0] rd1_data;
  logic        rd1_ready;
  logic        busy1;

  imem_backing_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_rw(req_rw), .mem_req_valid(req_valid),
    .mem_data_data(rd_data), .mem_data_ready(rd_ready), .mem_busy(busy)
  );

  imem_backing_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .mem_req_addr(req1_addr), .mem_req_data(req1_data),
    .mem_req_rw(req1_rw), .mem_req_valid(req1_valid),
    .mem_data_data(rd1_data), .mem_data_ready(rd1_ready), .mem_busy(busy1)
  );

  always #5 clk = ~clk;

  // ecount = number of rising edges so far. A request accepted on edge k
  // must show ready at the negedge where ecount == k + LAT - 1.
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int          acc;
    int          rdy;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        sbq1[$];
  logic [31:0] model  [DEPTH];
  logic [31:0] model1 [DEPTH];
  logic [31:0] last_rd;
  logic [31:0] last_rd1;
  int          free_edge;
  int          free_edge1;
  int          vecs = 0;
  int          errs = 0;
  bit          busy_chk = 1'b0;

  // Monitor for the LATENCY=4 instance.
  always @(negedge clk) begin
    bit   bexp;
    exp_t e;
    if (busy_chk) begin
      bexp = (sbq.size() > 0) && (ecount >= sbq[0].acc) && (ecount <= sbq[0].rdy);
      vecs++;
      if (busy !== bexp) begin
        errs++;
        $display("FAIL busy @edge %0d: got %b expected %b", ecount, busy, bexp);
      end
    end
    if (rd_ready === 1'b1) begin
      vecs++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_ready @edge %0d: got ready=1 expected no pulse", ecount);
      end else begin
        e = sbq.pop_front();
        if (ecount != e.rdy) begin
          errs++;
          $display("FAIL ready_cycle: got edge %0d expected edge %0d", ecount, e.rdy);
        end
        vecs++;
        if (rd_data !== e.data) begin
          errs++;
          $display("FAIL rd_data @edge %0d: got %h expected %h", ecount, rd_data, e.data);
        end
      end
    end
  end

  // Monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rd1_ready === 1'b1) begin
      vecs++;
      if (sbq1.size() == 0) begin
        errs++;
        $display("FAIL lat1_unexpected_ready @edge %0d: got ready=1 expected no pulse", ecount);
      end else begin
        e = sbq1.pop_front();
        if (ecount != e.rdy) begin
          errs++;
          $display("FAIL lat1_ready_cycle: got edge %0d expected edge %0d", ecount, e.rdy);
        end
        vecs++;
        if (rd1_data !== e.data) begin
          errs++;
          $display("FAIL lat1_rd_data: got %h expected %h", rd1_data, e.data);
        end
      end
    end
  end

  // Call this just after a rising edge. It presents a request, predicts the
  // response from the reference model, and waits for the handshake. It then
  // either keeps valid high (gap=0) or idles for gap cycles.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] d, input int gap);
    exp_t e;
    int   idx;
    int   n;
    req_addr  = a;
    req_data  = d;
    req_rw    = wr;
    req_valid = 1'b1;
    e.acc = (ecount + 1 > free_edge) ? ecount + 1 : free_edge;
    e.rdy = e.acc + LAT - 1;
    idx   = int'(a[ADDR_W+1:2]);
    if (wr) begin
      if (WR) model[idx] = d;
      e.data = last_rd;
    end else begin
      e.data  = model[idx];
      last_rd = model[idx];
    end
    free_edge = e.acc + LAT + 1;
    sbq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_ready !== 1'b1 && n < 64);
    if (rd_ready !== 1'b1) begin
      vecs++;
      errs++;
      $display("FAIL ready_timeout: got no ready after %0d cycles expected ready at edge %0d", n, e.rdy);
      sbq.delete();
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // Same as issue, but for the LATENCY=1 instance and reads only.
  task automatic issue1(input logic [15:0] a, input int gap);
    exp_t e;
    int   n;
    req1_addr  = a;
    req1_rw    = 1'b0;
    req1_valid = 1'b1;
    e.acc = (ecount + 1 > free_edge1) ? ecount + 1 : free_edge1;
    e.rdy = e.acc + LAT1 - 1;
    e.data = model1[int'(a[ADDR_W+1:2])];
    last_rd1 = e.data;
    free_edge1 = e.acc + LAT1 + 1;
    sbq1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd1_ready !== 1'b1 && n < 64);
    if (rd1_ready !== 1'b1) begin
      vecs++;
      errs++;
      $display("FAIL lat1_ready_timeout: got no ready expected ready at edge %0d", e.rdy);
      sbq1.delete();
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      req1_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_rw     = 1'b0;
    req_valid  = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    req1_rw    = 1'b0;
    req1_valid = 1'b0;
    last_rd    = 32'd0;
    last_rd1   = 32'd0;

    for (int i = 0; i < DEPTH; i++) begin
      model[i]  = $urandom;
      model1[i] = $urandom;
    end
    model[16] = 32'hDEADBEEF;
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i]  <= model[i];
      dut1.mem[i] <= model1[i];
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    free_edge  = ecount + 1;
    free_edge1 = ecount + 1;
    @(negedge clk);
    check("reset_data",  rd_data, 32'd0);
    check("reset_ready", {31'd0, rd_ready}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    busy_chk = 1'b1;

    // Preloaded word 0x010 read via byte address 0x0040.
    issue(1'b0, 16'h0040, 32'd0, 2);

    // Reset two cycles mid-WAIT aborts a write: no ready, outputs cleared.
    busy_chk  = 1'b0;
    req_addr  = 16'h0100;
    req_data  = 32'hBAD0BAD0;
    req_rw    = 1'b1;
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_data",  rd_data, 32'd0);
    check("abort_ready", {31'd0, rd_ready}, 32'd0);
    repeat (LAT + 3) @(negedge clk);
    @(posedge clk); #1;
    last_rd   = 32'd0;
    free_edge = ecount + 1;
    busy_chk  = 1'b1;
    issue(1'b0, 16'h0100, 32'd0, 1);

    // Write then read the same word.
    issue(1'b1, 16'h0080, 32'h12345678, 0);
    issue(1'b0, 16'h0080, 32'd0, 1);

    // Eight sequential reads with valid held high.
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 16'(i * 4), 32'd0, (i == 7) ? 1 : 0);
    end

    // Aliasing: 0x4008 maps to word 0x002.
    issue(1'b0, 16'h4008, 32'd0, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 3) == 0, 16'($urandom), $urandom, $urandom_range(0, 2));
    end

    // LATENCY=1 instance: back-to-back reads with valid held high.
    for (int i = 0; i < 6; i++) begin
      issue1(16'($urandom), (i == 5) ? 1 : 0);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(sbq.size() + sbq1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
